// File: rtl/mux_pkg.sv
// Shared constants for the mux_two_four_eight selector block.
//   muxDefaultWidth : default data width of every data port
//   selTwoWidth     : width of the 2:1 select (s1)
//   selFourWidth    : width of the 4:1 select (s2)
//   selEightWidth   : width of the 8:1 select (s3)
package mux_pkg;

    localparam int unsigned muxDefaultWidth = 8;

    localparam int unsigned selTwoWidth   = 1;
    localparam int unsigned selFourWidth  = 2;
    localparam int unsigned selEightWidth = 3;

endpackage : mux_pkg

// File: rtl/mux_two_cell.sv
// Combinational WIDTH-bit 2:1 selector; the only building block of the
// selector trees in mux_two_four_eight. Holds no state.
// Ports:
//   a, b : data sources (WIDTH bits)
//   sel  : 0 selects a, 1 selects b
//   y    : selected value (combinational)
module mux_two_cell #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Default branch drives zeros so an X/Z select never infers a latch.
    always_comb begin
        y = '0;
        case (sel)
            1'b0:    y = a;
            1'b1:    y = b;
            default: y = '0;
        endcase
    end

endmodule : mux_two_cell

// File: rtl/mux_two_four_eight.sv
// Registered 2:1, 4:1 and 8:1 selectors sharing one set of data sources.
// Each path is selected combinationally and captured in its own output
// register, giving one clock of latency. The 4:1 and 8:1 selectors are
// binary trees of mux_two_cell, with bit 0 of the select resolving the
// leaf level.
//
// Optional feature: define MUX_PARITY_EN to add a registered even-parity
// (XOR reduction) bit for each selected value.
//
// Ports:
//   clk            : clock, rising edge active
//   rst            : synchronous active-high reset, clears all registers
//   en             : output-register load enable (hold when low)
//   a .. h         : data sources, WIDTH bits each
//   s1             : 2:1 select  (a, b)
//   s2             : 4:1 select  (a .. d)
//   s3             : 8:1 select  (a .. h)
//   mux_two_out    : registered 2:1 result
//   mux_four_out   : registered 4:1 result
//   mux_eight_out  : registered 8:1 result
//   mux_two_par    : (MUX_PARITY_EN) parity of the 2:1 selection
//   mux_four_par   : (MUX_PARITY_EN) parity of the 4:1 selection
//   mux_eight_par  : (MUX_PARITY_EN) parity of the 8:1 selection
module mux_two_four_eight
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = muxDefaultWidth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [WIDTH-1:0]         c,
    input  logic [WIDTH-1:0]         d,
    input  logic [WIDTH-1:0]         e,
    input  logic [WIDTH-1:0]         f,
    input  logic [WIDTH-1:0]         g,
    input  logic [WIDTH-1:0]         h,
    input  logic [selTwoWidth-1:0]   s1,
    input  logic [selFourWidth-1:0]  s2,
    input  logic [selEightWidth-1:0] s3,
    output logic [WIDTH-1:0]         mux_two_out,
    output logic [WIDTH-1:0]         mux_four_out,
    output logic [WIDTH-1:0]         mux_eight_out
`ifdef MUX_PARITY_EN
    ,
    output logic                     mux_two_par,
    output logic                     mux_four_par,
    output logic                     mux_eight_par
`endif
);

    logic [WIDTH-1:0] twoSelected;
    logic [WIDTH-1:0] fourSelected;
    logic [WIDTH-1:0] eightSelected;

    // 2:1 path: a single cell.
    mux_two_cell #(.WIDTH(WIDTH)) uTwo (
        .a   (a),
        .b   (b),
        .sel (s1[0]),
        .y   (twoSelected)
    );

    // 4:1 path: two leaf cells on s2[0], one root cell on s2[1].
    logic [WIDTH-1:0] fourAb;
    logic [WIDTH-1:0] fourCd;

    mux_two_cell #(.WIDTH(WIDTH)) uFourAb (
        .a   (a),
        .b   (b),
        .sel (s2[0]),
        .y   (fourAb)
    );

    mux_two_cell #(.WIDTH(WIDTH)) uFourCd (
        .a   (c),
        .b   (d),
        .sel (s2[0]),
        .y   (fourCd)
    );

    mux_two_cell #(.WIDTH(WIDTH)) uFourRoot (
        .a   (fourAb),
        .b   (fourCd),
        .sel (s2[1]),
        .y   (fourSelected)
    );

    // 8:1 path: four leaf cells on s3[0], two mid cells on s3[1],
    // one root cell on s3[2].
    logic [WIDTH-1:0] eightAb;
    logic [WIDTH-1:0] eightCd;
    logic [WIDTH-1:0] eightEf;
    logic [WIDTH-1:0] eightGh;
    logic [WIDTH-1:0] eightAd;
    logic [WIDTH-1:0] eightEh;

    mux_two_cell #(.WIDTH(WIDTH)) uEightAb (
        .a   (a),
        .b   (b),
        .sel (s3[0]),
        .y   (eightAb)
    );

    mux_two_cell #(.WIDTH(WIDTH)) uEightCd (
        .a   (c),
        .b   (d),
        .sel (s3[0]),
        .y   (eightCd)
    );

    mux_two_cell #(.WIDTH(WIDTH)) uEightEf (
        .a   (e),
        .b   (f),
        .sel (s3[0]),
        .y   (eightEf)
    );

    mux_two_cell #(.WIDTH(WIDTH)) uEightGh (
        .a   (g),
        .b   (h),
        .sel (s3[0]),
        .y   (eightGh)
    );

    mux_two_cell #(.WIDTH(WIDTH)) uEightAd (
        .a   (eightAb),
        .b   (eightCd),
        .sel (s3[1]),
        .y   (eightAd)
    );

    mux_two_cell #(.WIDTH(WIDTH)) uEightEh (
        .a   (eightEf),
        .b   (eightGh),
        .sel (s3[1]),
        .y   (eightEh)
    );

    mux_two_cell #(.WIDTH(WIDTH)) uEightRoot (
        .a   (eightAd),
        .b   (eightEh),
        .sel (s3[2]),
        .y   (eightSelected)
    );

    // Output registers: reset wins over en; en low holds all three.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_two_out   <= '0;
            mux_four_out  <= '0;
            mux_eight_out <= '0;
        end else if (en) begin
            mux_two_out   <= twoSelected;
            mux_four_out  <= fourSelected;
            mux_eight_out <= eightSelected;
        end
    end

`ifdef MUX_PARITY_EN
    // Parity registers track the data registers' load/hold/reset exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_two_par   <= 1'b0;
            mux_four_par  <= 1'b0;
            mux_eight_par <= 1'b0;
        end else if (en) begin
            mux_two_par   <= ^twoSelected;
            mux_four_par  <= ^fourSelected;
            mux_eight_par <= ^eightSelected;
        end
    end
`endif

endmodule : mux_two_four_eight

// File: tb/tb_mux_two_four_eight.sv
module tb_mux_two_four_eight;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] a, b, c, d, e, f, g, h;
    logic [0:0] s1;
    logic [1:0] s2;
    logic [2:0] s3;
    logic [7:0] mux_two_out;
    logic [7:0] mux_four_out;
    logic [7:0] mux_eight_out;
`ifdef MUX_PARITY_EN
    logic       mux_two_par;
    logic       mux_four_par;
    logic       mux_eight_par;
`endif

    int checks;
    int failures;

    mux_two_four_eight #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .a             (a),
        .b             (b),
        .c             (c),
        .d             (d),
        .e             (e),
        .f             (f),
        .g             (g),
        .h             (h),
        .s1            (s1),
        .s2            (s2),
        .s3            (s3),
        .mux_two_out   (mux_two_out),
        .mux_four_out  (mux_four_out),
        .mux_eight_out (mux_eight_out)
`ifdef MUX_PARITY_EN
        ,
        .mux_two_par   (mux_two_par),
        .mux_four_par  (mux_four_par),
        .mux_eight_par (mux_eight_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written source values indexed by select code.
    function automatic logic [7:0] srcVal(input int i);
        case (i)
            0: return 8'b0000_0000;
            1: return 8'b1111_1111;
            2: return 8'b1010_1010;
            3: return 8'b0101_0101;
            4: return 8'b1100_1100;
            5: return 8'b0011_0011;
            6: return 8'b1110_0000;
            7: return 8'b0000_1111;
            default: return 8'hxx;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        a = 8'h00; b = 8'hFF; c = 8'hAA; d = 8'h55;
        e = 8'hCC; f = 8'h33; g = 8'hE0; h = 8'h0F;
        s1 = 1'b1; s2 = 2'd2; s3 = 3'd6;
        tick(); tick();
        checks++;
        if (mux_two_out !== 8'h00) begin failures++; $display("FAIL reset_two: got %h want %h", mux_two_out, 8'h00); end
        checks++;
        if (mux_four_out !== 8'h00) begin failures++; $display("FAIL reset_four: got %h want %h", mux_four_out, 8'h00); end
        checks++;
        if (mux_eight_out !== 8'h00) begin failures++; $display("FAIL reset_eight: got %h want %h", mux_eight_out, 8'h00); end
`ifdef MUX_PARITY_EN
        checks++;
        if ({mux_two_par, mux_four_par, mux_eight_par} !== 3'b000) begin
            failures++;
            $display("FAIL reset_par: got %b want %b", {mux_two_par, mux_four_par, mux_eight_par}, 3'b000);
        end
`endif
        rst = 1'b0;
        tick();
        checks++;
        if (mux_two_out !== 8'hFF) begin failures++; $display("FAIL release_two: got %h want %h", mux_two_out, 8'hFF); end
        checks++;
        if (mux_four_out !== 8'hAA) begin failures++; $display("FAIL release_four: got %h want %h", mux_four_out, 8'hAA); end
        checks++;
        if (mux_eight_out !== 8'hE0) begin failures++; $display("FAIL release_eight: got %h want %h", mux_eight_out, 8'hE0); end
    endtask

    task automatic test_two();
        s1 = 1'b0;
        #1;
        checks++;
        if (mux_two_out !== 8'hFF) begin failures++; $display("FAIL two_latency: got %h want %h", mux_two_out, 8'hFF); end
        tick();
        checks++;
        if (mux_two_out !== 8'h00) begin failures++; $display("FAIL two_s1_0: got %h want %h", mux_two_out, 8'h00); end
        s1 = 1'b1;
        tick();
        checks++;
        if (mux_two_out !== 8'hFF) begin failures++; $display("FAIL two_s1_1: got %h want %h", mux_two_out, 8'hFF); end
        checks++;
        if (mux_four_out !== 8'hAA) begin failures++; $display("FAIL two_indep_four: got %h want %h", mux_four_out, 8'hAA); end
    endtask

    task automatic test_four();
        for (int i = 0; i < 4; i++) begin
            s2 = 2'(i);
            tick();
            checks++;
            if (mux_four_out !== srcVal(i)) begin
                failures++;
                $display("FAIL four_sel%0d: got %h want %h", i, mux_four_out, srcVal(i));
            end
            checks++;
            if (mux_two_out !== 8'hFF || mux_eight_out !== 8'hE0) begin
                failures++;
                $display("FAIL four_indep%0d: got two=%h eight=%h want two=ff eight=e0", i, mux_two_out, mux_eight_out);
            end
        end
    endtask

    task automatic test_eight();
        for (int i = 0; i < 8; i++) begin
            s3 = 3'(i);
            tick();
            checks++;
            if (mux_eight_out !== srcVal(i)) begin
                failures++;
                $display("FAIL eight_sel%0d: got %h want %h", i, mux_eight_out, srcVal(i));
            end
            checks++;
            if (mux_four_out !== 8'h55) begin
                failures++;
                $display("FAIL eight_indep%0d: got four=%h want 55", i, mux_four_out);
            end
        end
    endtask

    task automatic test_hold();
        s3 = 3'd6;
        tick();
        checks++;
        if (mux_eight_out !== 8'hE0) begin failures++; $display("FAIL hold_load: got %h want %h", mux_eight_out, 8'hE0); end
        en = 1'b0; s3 = 3'd7; s1 = 1'b0; s2 = 2'd0;
        tick(); tick();
        checks++;
        if (mux_eight_out !== 8'hE0) begin failures++; $display("FAIL hold_eight: got %h want %h", mux_eight_out, 8'hE0); end
        checks++;
        if (mux_two_out !== 8'hFF || mux_four_out !== 8'h55) begin
            failures++;
            $display("FAIL hold_others: got two=%h four=%h want two=ff four=55", mux_two_out, mux_four_out);
        end
        en = 1'b1;
        tick();
        checks++;
        if (mux_eight_out !== 8'h0F) begin failures++; $display("FAIL hold_resume: got %h want %h", mux_eight_out, 8'h0F); end
        checks++;
        if (mux_two_out !== 8'h00 || mux_four_out !== 8'h00) begin
            failures++;
            $display("FAIL hold_resume_others: got two=%h four=%h want 00 00", mux_two_out, mux_four_out);
        end
    endtask

`ifdef MUX_PARITY_EN
    task automatic test_parity();
        en = 1'b1; s1 = 1'b1; s2 = 2'd2; s3 = 3'd6;
        tick();
        checks++;
        if (mux_four_par !== 1'b0) begin failures++; $display("FAIL par_four: got %b want %b", mux_four_par, 1'b0); end
        checks++;
        if (mux_eight_par !== 1'b1) begin failures++; $display("FAIL par_eight: got %b want %b", mux_eight_par, 1'b1); end
        checks++;
        if (mux_two_par !== 1'b0) begin failures++; $display("FAIL par_two: got %b want %b", mux_two_par, 1'b0); end
        en = 1'b0; s3 = 3'd7;
        tick();
        checks++;
        if (mux_eight_par !== 1'b1) begin failures++; $display("FAIL par_hold: got %b want %b", mux_eight_par, 1'b1); end
        en = 1'b1;
        tick();
        checks++;
        if (mux_eight_par !== 1'b0) begin failures++; $display("FAIL par_resume: got %b want %b", mux_eight_par, 1'b0); end
        rst = 1'b1; s3 = 3'd6;
        tick();
        checks++;
        if (mux_eight_par !== 1'b0) begin failures++; $display("FAIL par_reset: got %b want %b", mux_eight_par, 1'b0); end
        rst = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_two();
        test_four();
        test_eight();
        test_hold();
`ifdef MUX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule : tb_mux_two_four_eight
